// File: rtl/level_sequencer_if.sv
// Handshake bundle between the level sequencer and the game datapath.
// The master drives the frame, keyboard, collision and player-position inputs; the slave drives the status outputs.
interface level_sequencer_if;
  logic        frame_tick;
  logic [7:0]  keycode;
  logic        hit;
  logic [11:0] ballX;
  logic [11:0] scrollX;
  logic [1:0]  healthbar;
  logic        playerFlag;
  logic        paused;
  logic        invuln;
  logic        gameOver;
  logic        win;

  modport master (
    output frame_tick, keycode, hit, ballX,
    input  scrollX, healthbar, playerFlag, paused, invuln, gameOver, win
  );

  modport slave (
    input  frame_tick, keycode, hit, ballX,
    output scrollX, healthbar, playerFlag, paused, invuln, gameOver, win
  );
endinterface

// File: rtl/level_sequencer.sv
// Frame-level run controller: sequences start/pause/play/win/lose and owns the
// scroll offset, the health counter and the post-hit invulnerability window.
module level_sequencer #(
  parameter int         LEVEL_END     = 2200,
  parameter int         SCROLL_STEP   = 2,
  parameter int         INVULN_FRAMES = 60,
  parameter int         MAX_HEALTH    = 3,
  parameter logic [7:0] KEY_START     = 8'h2C,
  parameter logic [7:0] KEY_PAUSE     = 8'h13
) (
  input  logic               Clk,
  input  logic               Reset,
  level_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    PAUSE = 3'd2,
    WIN   = 3'd3,
    LOSE  = 3'd4
  } state_t;

  state_t      state, stateNext;
  logic [7:0]  prevKey;
  logic [11:0] scrollReg, scrollNext;
  logic [1:0]  healthReg, healthNext;
  logic [6:0]  invulnCnt, invulnNext;
  logic        playerFlagReg, pausedReg, invulnReg, gameOverReg, winReg;

  logic        startEdge, pauseEdge;
  logic [12:0] scrollSum, finishSum;
  logic [11:0] scrollSat;
  logic        hitLive, lethalHit, finishReached;

  assign startEdge     = (bus.keycode == KEY_START) && (prevKey != KEY_START);
  assign pauseEdge     = (bus.keycode == KEY_PAUSE) && (prevKey != KEY_PAUSE);
  assign scrollSum     = {1'b0, scrollReg} + 13'(SCROLL_STEP);
  assign scrollSat     = (scrollSum > 13'(LEVEL_END)) ? 12'(LEVEL_END) : scrollSum[11:0];
  assign finishSum     = {1'b0, bus.ballX} + {1'b0, scrollReg};
  assign finishReached = finishSum > 13'(LEVEL_END);
  assign hitLive       = bus.hit && (invulnCnt == 7'd0);
  assign lethalHit     = hitLive && (healthReg == 2'd1);

  // Next-state and counter updates; a lethal hit outranks the finish line, and both outrank pause.
  always_comb begin
    stateNext  = state;
    scrollNext = scrollReg;
    healthNext = healthReg;
    invulnNext = invulnCnt;
    case (state)
      IDLE, WIN, LOSE: begin
        if (startEdge) begin
          stateNext  = RUN;
          scrollNext = 12'd0;
          healthNext = 2'(MAX_HEALTH);
          invulnNext = 7'd0;
        end
      end
      RUN: begin
        if (bus.frame_tick) begin
          scrollNext = scrollSat;
          if (invulnCnt != 7'd0) invulnNext = invulnCnt - 7'd1;
        end
        if (lethalHit) begin
          healthNext = 2'd0;
          stateNext  = LOSE;
        end else if (hitLive) begin
          healthNext = healthReg - 2'd1;
          invulnNext = 7'(INVULN_FRAMES);
        end
        if (!lethalHit) begin
          if (finishReached)  stateNext = WIN;
          else if (pauseEdge) stateNext = PAUSE;
        end
      end
      PAUSE: begin
        if (pauseEdge) stateNext = RUN;
      end
      default: begin
        stateNext  = IDLE;
        scrollNext = 12'd0;
        healthNext = 2'(MAX_HEALTH);
        invulnNext = 7'd0;
      end
    endcase
  end

  // Flags are decoded from the next state so they land in the same cycle as the state change.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state         <= IDLE;
      prevKey       <= 8'd0;
      scrollReg     <= 12'd0;
      healthReg     <= 2'(MAX_HEALTH);
      invulnCnt     <= 7'd0;
      playerFlagReg <= 1'b0;
      pausedReg     <= 1'b0;
      invulnReg     <= 1'b0;
      gameOverReg   <= 1'b0;
      winReg        <= 1'b0;
    end else begin
      state         <= stateNext;
      prevKey       <= bus.keycode;
      scrollReg     <= scrollNext;
      healthReg     <= healthNext;
      invulnCnt     <= invulnNext;
      playerFlagReg <= (stateNext == RUN);
      pausedReg     <= (stateNext == PAUSE);
      invulnReg     <= (invulnNext != 7'd0);
      gameOverReg   <= (stateNext == WIN) || (stateNext == LOSE);
      winReg        <= (stateNext == WIN);
    end
  end

  assign bus.scrollX    = scrollReg;
  assign bus.healthbar  = healthReg;
  assign bus.playerFlag = playerFlagReg;
  assign bus.paused     = pausedReg;
  assign bus.invuln     = invulnReg;
  assign bus.gameOver   = gameOverReg;
  assign bus.win        = winReg;

endmodule

// File: tb/tb_level_sequencer.sv
// Directed self-checking bench for level_sequencer; flags are compared packed as
// {playerFlag, paused, invuln, gameOver, win}.
module tb_level_sequencer;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  int   compareCount = 0;
  int   failCount = 0;

  level_sequencer_if bus ();

  level_sequencer dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  localparam logic [4:0] F_IDLE   = 5'b00000;
  localparam logic [4:0] F_RUN    = 5'b10000;
  localparam logic [4:0] F_RUNINV = 5'b10100;
  localparam logic [4:0] F_PAUSEI = 5'b01100;
  localparam logic [4:0] F_WIN    = 5'b00011;
  localparam logic [4:0] F_LOSE   = 5'b00010;

  // Drive one cycle of inputs, then sample 1 time unit after the capturing edge.
  task automatic applyStimulus(input logic ft, input logic [7:0] kc, input logic h, input logic [11:0] bx);
    bus.frame_tick = ft;
    bus.keycode    = kc;
    bus.hit        = h;
    bus.ballX      = bx;
    @(posedge Clk);
    #1;
  endtask

  task automatic runTicks(input int n, input logic [7:0] kc, input logic [11:0] bx);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, kc, 1'b0, bx);
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    compareCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkState(input string tag, input int scroll, input int health, input logic [4:0] flags);
    checkOutput({tag, ".scrollX"}, 16'(bus.scrollX), 16'(scroll));
    checkOutput({tag, ".health"}, 16'(bus.healthbar), 16'(health));
    checkOutput({tag, ".flags"},
                16'({bus.playerFlag, bus.paused, bus.invuln, bus.gameOver, bus.win}), 16'(flags));
  endtask

  initial begin
    bus.frame_tick = 1'b0;
    bus.keycode    = 8'h00;
    bus.hit        = 1'b0;
    bus.ballX      = 12'd0;

    // Reset state
    applyStimulus(1'b0, 8'h00, 1'b0, 12'd0);
    applyStimulus(1'b1, 8'h2C, 1'b1, 12'd0);
    checkState("reset", 0, 3, F_IDLE);
    Reset = 1'b0;
    applyStimulus(1'b1, 8'h00, 1'b0, 12'd0);
    checkState("idle_tick", 0, 3, F_IDLE);

    // Start, then a held start key must not disturb the run
    applyStimulus(1'b0, 8'h2C, 1'b0, 12'd100);
    checkState("start", 0, 3, F_RUN);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 8'h2C, 1'b0, 12'd100);
    checkState("start_held", 0, 3, F_RUN);

    // Scrolling and the finish line (2200 exactly is not a win, 2201 is)
    runTicks(100, 8'h00, 12'd100);
    checkState("scroll100", 200, 3, F_RUN);
    applyStimulus(1'b0, 8'h00, 1'b0, 12'd2000);
    checkState("finish_eq", 200, 3, F_RUN);
    applyStimulus(1'b0, 8'h00, 1'b0, 12'd2001);
    checkState("win", 200, 3, F_WIN);
    runTicks(5, 8'h00, 12'd2001);
    checkState("win_hold", 200, 3, F_WIN);
    applyStimulus(1'b0, 8'h2C, 1'b0, 12'd0);
    checkState("restart_win", 0, 3, F_RUN);

    // Hit with simultaneous tick reloads the window; hits during the window are ignored
    applyStimulus(1'b1, 8'h2C, 1'b1, 12'd0);
    checkState("hit1", 2, 2, F_RUNINV);
    runTicks(10, 8'h2C, 12'd0);
    applyStimulus(1'b0, 8'h2C, 1'b1, 12'd0);
    checkState("hit_ignored", 22, 2, F_RUNINV);
    runTicks(49, 8'h2C, 12'd0);
    checkState("invuln_last", 120, 2, F_RUNINV);
    runTicks(1, 8'h2C, 12'd0);
    checkState("invuln_end", 122, 2, F_RUN);
    applyStimulus(1'b0, 8'h2C, 1'b1, 12'd0);
    checkState("hit2", 122, 1, F_RUNINV);

    // Pause freezes everything; start is ignored while paused
    applyStimulus(1'b0, 8'h13, 1'b0, 12'd0);
    checkState("pause", 122, 1, F_PAUSEI);
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 8'h13, 1'b1, 12'd0);
    checkState("pause_frozen", 122, 1, F_PAUSEI);
    applyStimulus(1'b0, 8'h2C, 1'b0, 12'd0);
    checkState("pause_start", 122, 1, F_PAUSEI);
    applyStimulus(1'b0, 8'h13, 1'b0, 12'd0);
    checkState("unpause", 122, 1, F_RUNINV);
    runTicks(59, 8'h13, 12'd0);
    checkState("cnt_kept", 240, 1, F_RUNINV);
    runTicks(1, 8'h13, 12'd0);
    checkState("cnt_zero", 242, 1, F_RUN);

    // Lethal hit on the same cycle as the finish line gives LOSE
    applyStimulus(1'b0, 8'h13, 1'b1, 12'd2000);
    checkState("lose", 242, 0, F_LOSE);
    applyStimulus(1'b1, 8'h00, 1'b0, 12'd2000);
    applyStimulus(1'b0, 8'h13, 1'b0, 12'd2000);
    checkState("lose_hold", 242, 0, F_LOSE);
    applyStimulus(1'b0, 8'h2C, 1'b0, 12'd0);
    checkState("restart_lose", 0, 3, F_RUN);

    // Reset mid-run outranks a tick and a hit
    runTicks(250, 8'h2C, 12'd0);
    applyStimulus(1'b0, 8'h2C, 1'b1, 12'd0);
    checkState("midrun", 500, 2, F_RUNINV);
    Reset = 1'b1;
    applyStimulus(1'b1, 8'h00, 1'b1, 12'd0);
    checkState("midrun_reset", 0, 3, F_IDLE);
    Reset = 1'b0;

    // Saturation at the level end, win while start is held, then restart
    applyStimulus(1'b0, 8'h2C, 1'b0, 12'd0);
    checkState("start2", 0, 3, F_RUN);
    runTicks(1100, 8'h2C, 12'd0);
    checkState("saturate", 2200, 3, F_RUN);
    runTicks(2, 8'h2C, 12'd0);
    checkState("saturate_hold", 2200, 3, F_RUN);
    applyStimulus(1'b0, 8'h2C, 1'b0, 12'd1);
    checkState("win_sat", 2200, 3, F_WIN);
    applyStimulus(1'b1, 8'h2C, 1'b1, 12'd1);
    checkState("win_held_key", 2200, 3, F_WIN);
    applyStimulus(1'b0, 8'h00, 1'b0, 12'd1);
    applyStimulus(1'b0, 8'h2C, 1'b0, 12'd1);
    checkState("restart_sat", 0, 3, F_RUN);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
